// File: rtl/parity_frame_tx.sv
// Serial framing transmitter: start bit, four data bits LSB first, parity bit, stop bit.
// Bit timing comes from a BAUD_DIV-cycle divider; the line idles high.
module parity_frame_tx #(
  parameter int BAUD_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in_data,
  input  logic       in_parity,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int               CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       bit_idx_q;
  logic [4:0]       shreg_q;
  logic             tx_q;
  logic             done_q;
  logic             bit_end;

  // With BAUD_DIV=1 the counter is pinned at zero and every cycle is a bit boundary.
  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            shreg_q   <= {in_parity, in_data};
            state_q   <= START;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= DATA;
            tx_q    <= shreg_q[0];
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q     <= '0;
            shreg_q   <= {1'b0, shreg_q[4:1]};
            bit_idx_q <= bit_idx_q + 2'd1;
            // After the fourth shift the parity bit sits at the bottom, so the
            // next line value is always shreg_q[1].
            tx_q      <= shreg_q[1];
            if (bit_idx_q == 2'd3) begin
              state_q <= PARITY;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        PARITY: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= STOP;
            tx_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  // Ready is gated by rst_n so it drops at once when reset is asserted.
  assign in_ready = (state_q == IDLE) && rst_n;
  assign busy     = (state_q != IDLE);
  assign tx       = tx_q;
  assign done     = done_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed bench for parity_frame_tx: one instance at BAUD_DIV=4, one at BAUD_DIV=1.
module tb_parity_frame_tx;

  logic       clk;
  logic       rst_n;
  logic [3:0] d4_data;
  logic       d4_par, d4_valid, d4_ready, d4_tx, d4_busy, d4_done;
  logic [3:0] d1_data;
  logic       d1_par, d1_valid, d1_ready, d1_tx, d1_busy, d1_done;

  int n_tests;
  int n_fail;

  logic tx_log   [0:63];
  logic busy_log [0:63];
  logic done_log [0:63];
  logic rdy_log  [0:63];

  parity_frame_tx #(.BAUD_DIV(4)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (d4_data),
    .in_parity(d4_par),
    .in_valid (d4_valid),
    .in_ready (d4_ready),
    .tx       (d4_tx),
    .busy     (d4_busy),
    .done     (d4_done)
  );

  parity_frame_tx #(.BAUD_DIV(1)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (d1_data),
    .in_parity(d1_par),
    .in_valid (d1_valid),
    .in_ready (d1_ready),
    .tx       (d1_tx),
    .busy     (d1_busy),
    .done     (d1_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records n cycles of outputs; the caller is positioned 1 time unit after an edge.
  task automatic capture(input bit sel1, input int n);
    for (int c = 0; c < n; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      tx_log[c]   = sel1 ? d1_tx    : d4_tx;
      busy_log[c] = sel1 ? d1_busy  : d4_busy;
      done_log[c] = sel1 ? d1_done  : d4_done;
      rdy_log[c]  = sel1 ? d1_ready : d4_ready;
    end
  endtask

  // Presents a frame to the BAUD_DIV=4 instance and returns 1 unit into the first start cycle.
  task automatic send4(input logic [3:0] data, input logic par, input bit hold);
    d4_data  = data;
    d4_par   = par;
    d4_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) d4_valid = 1'b0;
  endtask

  task automatic test_reset;
    d4_valid = 1'b1;
    d4_data  = 4'b1111;
    d4_par   = 1'b0;
    d1_valid = 1'b0;
    d1_data  = 4'b0000;
    d1_par   = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({d4_tx, d4_busy, d4_done, d4_ready} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_hold got tx/busy/done/rdy=%b exp 1000", {d4_tx, d4_busy, d4_done, d4_ready});
    end
    d4_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if ({d4_tx, d4_busy, d4_done, d4_ready} !== 4'b1001) begin
      n_fail++;
      $display("FAIL reset_release got tx/busy/done/rdy=%b exp 1001", {d4_tx, d4_busy, d4_done, d4_ready});
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({d4_tx, d4_busy, d1_tx, d1_busy} !== 4'b1010) begin
      n_fail++;
      $display("FAIL reset_no_frame got %b exp 1010", {d4_tx, d4_busy, d1_tx, d1_busy});
    end
  endtask

  task automatic test_single_frame;
    logic [6:0] exp;
    exp = 7'b1010110;  // line order 0,1,1,0,1,0,1
    send4(4'b1011, 1'b0, 1'b0);
    capture(1'b0, 30);
    for (int c = 0; c < 28; c++) begin
      n_tests++;
      if ({tx_log[c], busy_log[c], done_log[c], rdy_log[c]} !== {exp[c/4], 3'b100}) begin
        n_fail++;
        $display("FAIL single_bit cyc%0d got tx/busy/done/rdy=%b exp %b", c,
                 {tx_log[c], busy_log[c], done_log[c], rdy_log[c]}, {exp[c/4], 3'b100});
      end
    end
    n_tests++;
    if ({tx_log[28], busy_log[28], done_log[28], rdy_log[28]} !== 4'b1011) begin
      n_fail++;
      $display("FAIL single_done got tx/busy/done/rdy=%b exp 1011",
               {tx_log[28], busy_log[28], done_log[28], rdy_log[28]});
    end
    n_tests++;
    if ({tx_log[29], busy_log[29], done_log[29]} !== 3'b100) begin
      n_fail++;
      $display("FAIL single_after got tx/busy/done=%b exp 100", {tx_log[29], busy_log[29], done_log[29]});
    end
  endtask

  task automatic test_back_to_back;
    logic [6:0] exp1, exp2;
    exp1 = 7'b1100000;  // 0000 p=1 -> 0,0,0,0,0,1,1
    exp2 = 7'b1111110;  // 1111 p=1 -> 0,1,1,1,1,1,1
    send4(4'b0000, 1'b1, 1'b1);
    d4_data = 4'b1111;
    capture(1'b0, 57);
    for (int c = 0; c < 28; c++) begin
      n_tests++;
      if ({tx_log[c], busy_log[c], done_log[c]} !== {exp1[c/4], 2'b10}) begin
        n_fail++;
        $display("FAIL b2b_f1 cyc%0d got tx/busy/done=%b exp %b", c,
                 {tx_log[c], busy_log[c], done_log[c]}, {exp1[c/4], 2'b10});
      end
    end
    n_tests++;
    if ({tx_log[28], busy_log[28], done_log[28], rdy_log[28]} !== 4'b1011) begin
      n_fail++;
      $display("FAIL b2b_gap got tx/busy/done/rdy=%b exp 1011",
               {tx_log[28], busy_log[28], done_log[28], rdy_log[28]});
    end
    for (int c = 29; c < 57; c++) begin
      n_tests++;
      if ({tx_log[c], busy_log[c], done_log[c]} !== {exp2[(c-29)/4], 2'b10}) begin
        n_fail++;
        $display("FAIL b2b_f2 cyc%0d got tx/busy/done=%b exp %b", c,
                 {tx_log[c], busy_log[c], done_log[c]}, {exp2[(c-29)/4], 2'b10});
      end
    end
    @(posedge clk);
    #1;
    n_tests++;
    if ({d4_tx, d4_busy, d4_done} !== 3'b101) begin
      n_fail++;
      $display("FAIL b2b_done2 got tx/busy/done=%b exp 101", {d4_tx, d4_busy, d4_done});
    end
    d4_valid = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if ({d4_tx, d4_busy, d4_done} !== 3'b100) begin
      n_fail++;
      $display("FAIL b2b_stop got tx/busy/done=%b exp 100", {d4_tx, d4_busy, d4_done});
    end
  endtask

  task automatic test_input_change;
    logic [6:0] exp;
    exp = 7'b1001010;  // 0101 p=0 -> 0,1,0,1,0,0,1
    send4(4'b0101, 1'b0, 1'b0);
    fork
      capture(1'b0, 29);
      begin
        repeat (6) @(posedge clk);
        #2;
        d4_data = 4'b1010;
        d4_par  = 1'b1;
      end
    join
    for (int c = 0; c < 28; c++) begin
      n_tests++;
      if ({tx_log[c], busy_log[c], rdy_log[c]} !== {exp[c/4], 2'b10}) begin
        n_fail++;
        $display("FAIL midchg cyc%0d got tx/busy/rdy=%b exp %b", c,
                 {tx_log[c], busy_log[c], rdy_log[c]}, {exp[c/4], 2'b10});
      end
    end
    n_tests++;
    if ({tx_log[28], done_log[28]} !== 2'b11) begin
      n_fail++;
      $display("FAIL midchg_done got tx/done=%b exp 11", {tx_log[28], done_log[28]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset;
    logic [6:0] exp;
    send4(4'b1011, 1'b0, 1'b0);
    repeat (21) @(posedge clk);
    #1;
    n_tests++;
    if ({d4_tx, d4_busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL arst_parity got tx/busy=%b exp 01", {d4_tx, d4_busy});
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({d4_tx, d4_busy, d4_done, d4_ready} !== 4'b1000) begin
      n_fail++;
      $display("FAIL arst_immediate got tx/busy/done/rdy=%b exp 1000", {d4_tx, d4_busy, d4_done, d4_ready});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if ({d4_tx, d4_busy, d4_done, d4_ready} !== 4'b1001) begin
        n_fail++;
        $display("FAIL arst_idle cyc%0d got tx/busy/done/rdy=%b exp 1001", c,
                 {d4_tx, d4_busy, d4_done, d4_ready});
      end
    end
    exp = 7'b1000110;  // 0011 p=0 -> 0,1,1,0,0,0,1
    send4(4'b0011, 1'b0, 1'b0);
    capture(1'b0, 29);
    for (int c = 0; c < 28; c++) begin
      n_tests++;
      if ({tx_log[c], busy_log[c], done_log[c]} !== {exp[c/4], 2'b10}) begin
        n_fail++;
        $display("FAIL arst_next cyc%0d got tx/busy/done=%b exp %b", c,
                 {tx_log[c], busy_log[c], done_log[c]}, {exp[c/4], 2'b10});
      end
    end
    n_tests++;
    if ({tx_log[28], busy_log[28], done_log[28]} !== 3'b101) begin
      n_fail++;
      $display("FAIL arst_next_done got tx/busy/done=%b exp 101", {tx_log[28], busy_log[28], done_log[28]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_baud1;
    logic [6:0] exp1, exp2;
    exp1 = 7'b1101100;  // 0110 p=1 -> 0,0,1,1,0,1,1
    exp2 = 7'b1010010;  // 1001 p=0 -> 0,1,0,0,1,0,1
    d1_data  = 4'b0110;
    d1_par   = 1'b1;
    d1_valid = 1'b1;
    @(posedge clk);
    #1;
    d1_data = 4'b1001;
    d1_par  = 1'b0;
    capture(1'b1, 8);
    for (int c = 0; c < 7; c++) begin
      n_tests++;
      if ({tx_log[c], busy_log[c], done_log[c]} !== {exp1[c], 2'b10}) begin
        n_fail++;
        $display("FAIL baud1_f1 cyc%0d got tx/busy/done=%b exp %b", c,
                 {tx_log[c], busy_log[c], done_log[c]}, {exp1[c], 2'b10});
      end
    end
    n_tests++;
    if ({tx_log[7], busy_log[7], done_log[7], rdy_log[7]} !== 4'b1011) begin
      n_fail++;
      $display("FAIL baud1_done1 got tx/busy/done/rdy=%b exp 1011",
               {tx_log[7], busy_log[7], done_log[7], rdy_log[7]});
    end
    @(posedge clk);
    #1;
    d1_valid = 1'b0;
    capture(1'b1, 8);
    for (int c = 0; c < 7; c++) begin
      n_tests++;
      if ({tx_log[c], busy_log[c], done_log[c]} !== {exp2[c], 2'b10}) begin
        n_fail++;
        $display("FAIL baud1_f2 cyc%0d got tx/busy/done=%b exp %b", c,
                 {tx_log[c], busy_log[c], done_log[c]}, {exp2[c], 2'b10});
      end
    end
    n_tests++;
    if ({tx_log[7], busy_log[7], done_log[7]} !== 3'b101) begin
      n_fail++;
      $display("FAIL baud1_done2 got tx/busy/done=%b exp 101", {tx_log[7], busy_log[7], done_log[7]});
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_input_change();
    test_async_reset();
    test_baud1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
